firebird7_in_gate1_tessent_data_mux_ctrl_w19: RTL and testbench
===============================================================

FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CTRL_W19 -- requirements
Module: firebird7_in_gate1_tessent_data_mux_ctrl_w19

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, SHALL set the number of ijtag_tck cycles between an override data update and ijtag_select assertion; legal range 1..15.
REQ-002 ijtag_tck  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 ijtag_reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 ijtag_sel  in  1  SHALL enable capture/shift/update when high.
REQ-005 ijtag_si  in  1  SHALL be the scan input.
REQ-006 ijtag_ce  in  1  SHALL be capture enable.
REQ-007 ijtag_se  in  1  SHALL be shift enable.
REQ-008 ijtag_ue  in  1  SHALL be update enable.
REQ-009 functional_data_in  in  19  SHALL be the functional mux input, observed on capture.
REQ-010 ijtag_so  out  1  SHALL be the scan output, equal to shift-register bit 0.
REQ-011 ijtag_select  out  1  SHALL drive the data mux select.
REQ-012 ijtag_data_out  out  19  SHALL drive the data mux ijtag_data_in.

Function
REQ-013 The block SHALL hold a 20-bit shift register SR: SR[19] = select request, SR[18:0] = override data.
REQ-014 Capture (sel & ce) SHALL load SR <= {ijtag_select, functional_data_in}.
REQ-015 Shift (sel & se & !ce) SHALL load SR <= {ijtag_si, SR[19:1]}; ce has priority over se.
REQ-016 With ijtag_sel low, SR, state and outputs SHALL hold, except the settle counter, which continues counting in ARM.
REQ-017 Update (sel & ue) SHALL sample the pre-edge SR value, regardless of a same-edge capture or shift.
REQ-018 FSM states SHALL be FUNC, ARM and OVERRIDE; reset state FUNC.
REQ-019 FUNC: on an update with SR[19]=1, ijtag_data_out <= SR[18:0], counter <= SETTLE_CYCLES, next ARM; on an update with SR[19]=0, ijtag_data_out <= SR[18:0] and the state remains FUNC.
REQ-020 ARM: the counter SHALL decrement each cycle; when it reaches 0, ijtag_select <= 1 and next OVERRIDE; ijtag_select SHALL stay 0 throughout ARM.
REQ-021 ARM, update with SR[19]=1: data reloaded, counter restarted at SETTLE_CYCLES, state remains ARM.
REQ-022 ARM, update with SR[19]=0: data loaded, counter cleared, next FUNC; ijtag_select never asserts.
REQ-023 OVERRIDE, update with SR[19]=1: ijtag_data_out <= SR[18:0] in the same edge; ijtag_select stays 1.
REQ-024 OVERRIDE, update with SR[19]=0: ijtag_select <= 0 on that edge (break before data change), ijtag_data_out <= SR[18:0], next FUNC.
REQ-025 With SETTLE_CYCLES=1, ijtag_select SHALL rise exactly 2 tck edges after the update edge; the general latency SHALL be SETTLE_CYCLES+1 edges.
REQ-026 ijtag_select SHALL be 1 if and only if the state is OVERRIDE; it is driven from a flop (glitch-free).

Reset
REQ-027 Asserting ijtag_reset low SHALL immediately clear SR to 0, ijtag_data_out to 0, ijtag_select to 0, the counter to 0 and the state to FUNC, including mid-ARM or mid-OVERRIDE.
REQ-028 After ijtag_reset deasserts, the first rising edge of ijtag_tck SHALL be a normal operating edge.

Verification
REQ-029 Reset, shift 20 bits of {1, 19'h5A5A5}, then pulse ue, with SETTLE_CYCLES=1 -> ijtag_data_out=19'h5A5A5 on the update edge; ijtag_select=0 on the next edge and 1 on the edge after.
REQ-030 In OVERRIDE, capture with functional_data_in=19'h7FFFF, then shift out 20 bits -> ijtag_so sequence LSB-first = 19'h7FFFF followed by 1.
REQ-031 SETTLE_CYCLES=4, update {1,X}, then update {0,19'h00001} 2 edges later -> ijtag_select never rises; ijtag_data_out=19'h00001; state FUNC.
REQ-032 In OVERRIDE, update {0,19'h12345} -> ijtag_select=0 and ijtag_data_out=19'h12345 on the same edge; subsequent edges hold.
REQ-033 Assert ijtag_reset mid-ARM and separately mid-shift -> all outputs and SR read 0 without a clock edge; after release, no spurious select assertion.
REQ-034 Assert ce, se and ue together with SR=20'h80001 -> the update uses 20'h80001 (enters ARM) and SR <= capture value (ce wins over se).

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// IJTAG-controlled data mux controller: a 20-bit scan register feeds override
// data and a select request that asserts only after a programmable settle time.
module firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        ijtag_tck,
  input  logic        ijtag_reset,
  input  logic        ijtag_sel,
  input  logic        ijtag_si,
  input  logic        ijtag_ce,
  input  logic        ijtag_se,
  input  logic        ijtag_ue,
  input  logic [18:0] functional_data_in,
  output logic        ijtag_so,
  output logic        ijtag_select,
  output logic [18:0] ijtag_data_out
);

  typedef enum logic [1:0] {
    FUNC     = 2'd0,
    ARM      = 2'd1,
    OVERRIDE = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [18:0] data_q, data_d;
  logic        select_q, select_d;
  logic [3:0]  cnt_q, cnt_d;

  logic capture_en, shift_en, update_en;

  assign capture_en = ijtag_sel & ijtag_ce;
  assign shift_en   = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign update_en  = ijtag_sel & ijtag_ue;

  always_comb begin
    sr_d     = sr_q;
    data_d   = data_q;
    select_d = select_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    if (capture_en) begin
      sr_d = {select_q, functional_data_in};
    end else if (shift_en) begin
      sr_d = {ijtag_si, sr_q[19:1]};
    end

    // Update decisions use sr_q, i.e. the value before any same-edge capture/shift.
    case (state_q)
      FUNC: begin
        if (update_en) begin
          data_d = sr_q[18:0];
          if (sr_q[19]) begin
            cnt_d   = SETTLE;
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (update_en) begin
          data_d = sr_q[18:0];
          if (sr_q[19]) begin
            cnt_d = SETTLE;
          end else begin
            cnt_d   = 4'd0;
            state_d = FUNC;
          end
        end else if (!ijtag_sel) begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        end else if (cnt_q == 4'd0) begin
          select_d = 1'b1;
          state_d  = OVERRIDE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      OVERRIDE: begin
        if (update_en) begin
          data_d = sr_q[18:0];
          if (!sr_q[19]) begin
            select_d = 1'b0;
            state_d  = FUNC;
          end
        end
      end
      default: begin
        select_d = 1'b0;
        cnt_d    = 4'd0;
        state_d  = FUNC;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q  <= FUNC;
      sr_q     <= 20'd0;
      data_q   <= 19'd0;
      select_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      data_q   <= data_d;
      select_q <= select_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ijtag_so       = sr_q[0];
  assign ijtag_select   = select_q;
  assign ijtag_data_out = data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// Directed bench: two instances (SETTLE_CYCLES=1 and 4) share one stimulus stream.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19;

  logic        tck = 1'b0;
  logic        rst_n;
  logic        sel, si, ce, se, ue;
  logic [18:0] fdi;
  logic        so1, so4, select1, select4;
  logic [18:0] data1, data4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(.SETTLE_CYCLES(1)) dut1 (
    .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_si(si),
    .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .functional_data_in(fdi),
    .ijtag_so(so1), .ijtag_select(select1), .ijtag_data_out(data1)
  );

  firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(.SETTLE_CYCLES(4)) dut4 (
    .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_si(si),
    .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .functional_data_in(fdi),
    .ijtag_so(so4), .ijtag_select(select4), .ijtag_data_out(data4)
  );

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic idle();
    sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  // Shift v in LSB-first while recording the bits that fall out of each instance.
  task automatic shift20(input logic [19:0] v, output logic [19:0] o1, output logic [19:0] o4);
    sel = 1'b1; se = 1'b1; ce = 1'b0; ue = 1'b0;
    for (int i = 0; i < 20; i++) begin
      si    = v[i];
      o1[i] = so1;
      o4[i] = so4;
      tick();
    end
    idle();
  endtask

  task automatic update();
    sel = 1'b1; ue = 1'b1;
    tick();
    ue = 1'b0;
  endtask

  logic [19:0] o1, o4;

  initial begin
    idle();
    fdi   = 19'h0;
    rst_n = 1'b0;
    #2;
    chk("reset_select", {19'd0, select1}, 20'd0);
    chk("reset_data", {1'b0, data1}, 20'd0);
    chk("reset_so", {19'd0, so1}, 20'd0);
    chk("reset_data4", {1'b0, data4}, 20'd0);
    #6;
    rst_n = 1'b1;
    tick();

    // Basic override entry with one settle cycle
    shift20({1'b1, 19'h5A5A5}, o1, o4);
    update();
    chk("upd_data", {1'b0, data1}, {1'b0, 19'h5A5A5});
    chk("upd_select_e0", {19'd0, select1}, 20'd0);
    tick();
    chk("settle_e1", {19'd0, select1}, 20'd0);
    tick();
    chk("settle_e2", {19'd0, select1}, 20'd1);
    chk("settle4_e2", {19'd0, select4}, 20'd0);

    // Capture reflects current select: 1 on dut1, still 0 on dut4
    sel = 1'b1; ce = 1'b1; fdi = 19'h7FFFF;
    tick();
    idle();
    shift20(20'd0, o1, o4);
    chk("capture_so_ovr", o1, 20'hFFFFF);
    chk("capture_so_arm4", o4, 20'h7FFFF);
    chk("shift_keeps_sel", {19'd0, select1}, 20'd1);

    // Leave override: select drops on the same edge as data changes
    shift20({1'b0, 19'h12345}, o1, o4);
    update();
    chk("exit_select", {19'd0, select1}, 20'd0);
    chk("exit_data", {1'b0, data1}, {1'b0, 19'h12345});
    chk("exit_select4", {19'd0, select4}, 20'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exit_hold_sel", {19'd0, select1}, 20'd0);
      chk("exit_hold_data", {1'b0, data1}, {1'b0, 19'h12345});
    end

    // Data change while staying in override
    shift20({1'b1, 19'h00ABC}, o1, o4);
    update();
    tick();
    tick();
    chk("reenter_sel", {19'd0, select1}, 20'd1);
    shift20({1'b1, 19'h3C3C3}, o1, o4);
    update();
    chk("ovr_data", {1'b0, data1}, {1'b0, 19'h3C3C3});
    chk("ovr_sel", {19'd0, select1}, 20'd1);
    chk("ovr_sel4", {19'd0, select4}, 20'd1);

    // With sel low, capture/shift/update must all be ignored
    sel = 1'b0; ce = 1'b1; se = 1'b1; ue = 1'b1; fdi = 19'h0;
    tick();
    tick();
    idle();
    update();
    chk("sel_low_hold_data", {1'b0, data1}, {1'b0, 19'h3C3C3});
    chk("sel_low_hold_sel", {19'd0, select1}, 20'd1);

    // Simultaneous ce/se/ue: update sees the old SR, capture wins the SR load
    do_reset();
    shift20(20'h80001, o1, o4);
    ce = 1'b1; se = 1'b1; ue = 1'b1; fdi = 19'h0F0F0;
    tick();
    idle();
    chk("ceseue_data", {1'b0, data1}, 20'h00001);
    chk("ceseue_sel", {19'd0, select1}, 20'd0);
    tick();
    tick();
    chk("ceseue_arm_sel", {19'd0, select1}, 20'd1);
    shift20(20'd0, o1, o4);
    chk("ceseue_sr", o1, 20'h0F0F0);
    chk("ceseue_sr4", o4, 20'h0F0F0);

    // Abort during ARM: select must never rise
    do_reset();
    shift20({1'b1, 19'h11111}, o1, o4);
    ce = 1'b1; ue = 1'b1; fdi = 19'h00001;
    tick();
    idle();
    chk("abort_e0_data", {1'b0, data4}, {1'b0, 19'h11111});
    chk("abort_e0_sel", {19'd0, select4}, 20'd0);
    tick();
    chk("abort_e1_sel", {19'd0, select4}, 20'd0);
    update();
    chk("abort_e2_data4", {1'b0, data4}, 20'h00001);
    chk("abort_e2_data1", {1'b0, data1}, 20'h00001);
    chk("abort_e2_sel1", {19'd0, select1}, 20'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_hold", {18'd0, select4, select1}, 20'd0);
    end

    // Reset in the middle of ARM
    shift20({1'b1, 19'h2AAAA}, o1, o4);
    update();
    chk("arm_data", {1'b0, data1}, {1'b0, 19'h2AAAA});
    rst_n = 1'b0;
    #2;
    chk("rst_arm_data", {1'b0, data1}, 20'd0);
    chk("rst_arm_sel", {18'd0, select4, select1}, 20'd0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_arm_no_sel", {18'd0, select4, select1}, 20'd0);
    end
    shift20(20'd0, o1, o4);
    chk("rst_arm_sr", o1, 20'd0);

    // Reset in the middle of a shift
    shift20(20'hFFFFF, o1, o4);
    chk("pre_rst_so", {19'd0, so1}, 20'd1);
    sel = 1'b1; se = 1'b1; si = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #2;
    chk("rst_shift_so", {18'd0, so4, so1}, 20'd0);
    chk("rst_shift_data", {1'b0, data1}, 20'd0);
    rst_n = 1'b1;
    #1;
    idle();
    shift20(20'd0, o1, o4);
    chk("rst_shift_sr", o1, 20'd0);
    chk("rst_shift_no_sel", {18'd0, select4, select1}, 20'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
